// File: rtl/loader_pkg.sv
// Shared types and constants for the UART ROM loader.
// Holds the loader and receiver FSM encodings plus field widths.
package loader_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_CHK,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/rom_uart_loader_if.sv
// ROM write port bundle driven by the loader.
// The master side produces address, data and a one-cycle strobe.
interface rom_uart_loader_if #(
    parameter int AW = 12,
    parameter int DW = 16
);

    logic [AW-1:0] rom_waddr;
    logic [DW-1:0] rom_wdata;
    logic          rom_we;

    modport master (output rom_waddr, rom_wdata, rom_we);
    modport slave  (input  rom_waddr, rom_wdata, rom_we);

endinterface

// File: rtl/rom_uart_loader_uart_rx.sv
// 8N1 UART byte receiver with 2-flop synchronizer and centre sampling.
// Emits a one-cycle byte_valid or stop_err after the stop bit sample.
module uart_rx
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    output logic              byte_valid,
    output logic [BYTE_W-1:0] rx_byte,
    output logic              stop_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    rx_state_e         st_q, st_d;
    logic              sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [BYTE_W-1:0] sh_q, sh_d, byte_q, byte_d;
    logic              valid_q, valid_d, err_q, err_d;

    always_comb begin
        sync1_d = rx;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        st_d    = st_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        sh_d    = sh_q;
        byte_d  = byte_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        unique case (st_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (prev_q && !sync2_q) st_d = RX_START;
            end
            RX_START: begin
                // Line high again at mid start bit: a glitch, not a start.
                if (cnt_q == HALF) begin
                    cnt_d = '0;
                    bit_d = '0;
                    st_d  = sync2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL) begin
                    cnt_d = '0;
                    sh_d  = {sync2_q, sh_q[BYTE_W-1:1]};
                    bit_d = bit_q + 1'b1;
                    if (bit_q == 3'd7) st_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL) begin
                    st_d = RX_IDLE;
                    if (sync2_q) begin
                        valid_d = 1'b1;
                        byte_d  = sh_q;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: st_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= RX_IDLE;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            st_q    <= st_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign byte_valid = valid_q;
    assign rx_byte    = byte_q;
    assign stop_err   = err_q;

endmodule

// File: rtl/rom_uart_loader.sv
// Serial program loader: UART frame -> sequential ROM writes, CPU held until done.
// LOADER_CHECKSUM_EN adds a trailing XOR check word and checksum_error output.
module rom_uart_loader
    import loader_pkg::*;
#(
    parameter int DATA_WIDTH         = 16,
    parameter int ROM_REGISTER_COUNT = 4096,
    parameter int CLK_FREQ           = 50_000_000,
    parameter int BAUD               = 115200,
    parameter int TIMEOUT_CLKS       = 50_000_000
) (
    input  logic                                CLK_50,
    input  logic                                resetN,
    input  logic                                uart_rx,
    rom_uart_loader_if.master                   rom,
    output logic                                cpu_holdN,
    output logic                                loading,
    output logic                                load_done,
    output logic [$clog2(ROM_REGISTER_COUNT):0] words_loaded,
    output logic                                frame_error,
    output logic                                timeout_error,
    output logic                                overflow
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic                                checksum_error
`endif
);

    localparam int AW  = $clog2(ROM_REGISTER_COUNT);
    localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
    localparam int TW  = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [AW:0]     DEPTH    = (AW + 1)'(ROM_REGISTER_COUNT);
    localparam logic [AW-1:0]   LAST     = AW'(ROM_REGISTER_COUNT - 1);
    localparam logic [16:0]     DEPTH17  = 17'(ROM_REGISTER_COUNT);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CLKS - 1);
`ifdef LOADER_CHECKSUM_EN
    localparam state_e          END_ST   = S_CHK;
`else
    localparam state_e          END_ST   = S_DONE;
`endif

    logic              bv, stop_err;
    logic [BYTE_W-1:0] rx_byte;

    uart_rx #(.CLKS_PER_BIT(CPB)) u_rx (
        .clk        (CLK_50),
        .rst_n      (resetN),
        .rx         (uart_rx),
        .byte_valid (bv),
        .rx_byte    (rx_byte),
        .stop_err   (stop_err)
    );

    state_e                state_q, state_d;
    logic [BYTE_W-1:0]     hi_q, hi_d;
    logic [WORD_W-1:0]     n_q, n_d, wcnt_q, wcnt_d, csum_q, csum_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [AW:0]           wl_q, wl_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic we_q, we_d, wdone_q, wdone_d, phase_q, phase_d;
    logic ferr_q, ferr_d, terr_q, terr_d, ovf_q, ovf_d;
`ifdef LOADER_CHECKSUM_EN
    logic cerr_q, cerr_d;
`endif
    logic active, abort;
    logic [WORD_W-1:0] word;

    assign active = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CHK);
    assign word   = {hi_q, rx_byte};

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        n_d     = n_q;
        wcnt_d  = wcnt_q;
        csum_d  = csum_q;
        addr_d  = addr_q;
        wl_d    = wl_q;
        wdata_d = wdata_q;
        phase_d = phase_q;
        ferr_d  = ferr_q;
        terr_d  = terr_q;
        ovf_d   = ovf_q;
`ifdef LOADER_CHECKSUM_EN
        cerr_d  = cerr_q;
`endif
        we_d    = 1'b0;
        wdone_d = 1'b0;
        abort   = 1'b0;
        tmo_d   = (active && !bv) ? tmo_q + 1'b1 : '0;
        unique case (state_q)
            S_IDLE: begin
                if (bv) begin
                    hi_d    = rx_byte;
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                if (bv) begin
                    n_d = word;
                    if (word == '0) state_d = S_DONE;
                    else state_d = S_DATA;
                    if ({1'b0, word} > DEPTH17) ovf_d = 1'b1;
                end
            end
            S_DATA: begin
                // Bookkeeping runs the cycle of the write so waddr holds through it.
                if (wdone_q) begin
                    wcnt_d = wcnt_q + 1'b1;
                    if (we_q) begin
                        wl_d = wl_q + 1'b1;
                        if (addr_q != LAST) addr_d = addr_q + 1'b1;
                    end
                    if (wcnt_q + 1'b1 == n_q) state_d = END_ST;
                end else if (bv) begin
                    if (!phase_q) begin
                        hi_d    = rx_byte;
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        wdata_d = DATA_WIDTH'(word);
                        csum_d  = csum_q ^ word;
                        we_d    = (wl_q < DEPTH);
                        wdone_d = 1'b1;
                    end
                end
            end
            S_CHK: begin
                if (bv) begin
                    if (!phase_q) begin
                        hi_d    = rx_byte;
                        phase_d = 1'b1;
                    end else if (word == csum_q) begin
                        state_d = S_DONE;
                    end else begin
`ifdef LOADER_CHECKSUM_EN
                        cerr_d = 1'b1;
`endif
                        abort  = 1'b1;
                    end
                end
            end
            S_DONE: ;
            default: state_d = S_IDLE;
        endcase
        if (stop_err && state_q != S_DONE) begin
            ferr_d = 1'b1;
            if (active) abort = 1'b1;
        end
        if (active && tmo_q == TMO_LAST) begin
            terr_d = 1'b1;
            abort  = 1'b1;
        end
        if (abort) begin
            state_d = S_IDLE;
            addr_d  = '0;
            wl_d    = '0;
            wcnt_d  = '0;
            csum_d  = '0;
            phase_d = 1'b0;
            tmo_d   = '0;
            we_d    = 1'b0;
            wdone_d = 1'b0;
        end
    end

    always_ff @(posedge CLK_50 or negedge resetN) begin
        if (!resetN) begin
            state_q <= S_IDLE;
            hi_q    <= '0;
            n_q     <= '0;
            wcnt_q  <= '0;
            csum_q  <= '0;
            addr_q  <= '0;
            wl_q    <= '0;
            wdata_q <= '0;
            tmo_q   <= '0;
            we_q    <= 1'b0;
            wdone_q <= 1'b0;
            phase_q <= 1'b0;
            ferr_q  <= 1'b0;
            terr_q  <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            cerr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            n_q     <= n_d;
            wcnt_q  <= wcnt_d;
            csum_q  <= csum_d;
            addr_q  <= addr_d;
            wl_q    <= wl_d;
            wdata_q <= wdata_d;
            tmo_q   <= tmo_d;
            we_q    <= we_d;
            wdone_q <= wdone_d;
            phase_q <= phase_d;
            ferr_q  <= ferr_d;
            terr_q  <= terr_d;
            ovf_q   <= ovf_d;
`ifdef LOADER_CHECKSUM_EN
            cerr_q  <= cerr_d;
`endif
        end
    end

    assign rom.rom_waddr  = addr_q;
    assign rom.rom_wdata  = wdata_q;
    assign rom.rom_we     = we_q;
    assign cpu_holdN      = (state_q == S_DONE);
    assign load_done      = (state_q == S_DONE);
    assign loading        = active;
    assign words_loaded   = wl_q;
    assign frame_error    = ferr_q;
    assign timeout_error  = terr_q;
    assign overflow       = ovf_q;
`ifdef LOADER_CHECKSUM_EN
    assign checksum_error = cerr_q;
`endif

endmodule

// File: tb/tb_rom_uart_loader.sv
// Directed bench for rom_uart_loader at 10 clocks per UART bit, 16-word ROM.
// Table of complete frames plus hand sequences for error, timeout and reset.
module tb_rom_uart_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       cpu_holdN, loading, load_done;
    logic [4:0] words_loaded;
    logic       frame_error, timeout_error, overflow;
`ifdef LOADER_CHECKSUM_EN
    logic       checksum_error;
`endif

    rom_uart_loader_if #(.AW(4), .DW(16)) rom_if ();

    rom_uart_loader #(
        .DATA_WIDTH(16), .ROM_REGISTER_COUNT(16),
        .CLK_FREQ(1_000_000), .BAUD(100_000), .TIMEOUT_CLKS(500)
    ) dut (
        .CLK_50(clk), .resetN(rst_n), .uart_rx(rx), .rom(rom_if),
        .cpu_holdN(cpu_holdN), .loading(loading), .load_done(load_done),
        .words_loaded(words_loaded), .frame_error(frame_error),
        .timeout_error(timeout_error), .overflow(overflow)
`ifdef LOADER_CHECKSUM_EN
        , .checksum_error(checksum_error)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    logic [3:0]  wa_q[$];
    logic [15:0] wd_q[$];
    logic [15:0] fw[32];
    int          fn;

    always @(negedge clk)
        if (rst_n && rom_if.rom_we) begin
            wa_q.push_back(rom_if.rom_waddr);
            wd_q.push_back(rom_if.rom_wdata);
        end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        wa_q.delete();
        wd_q.delete();
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (10) @(negedge clk);
        end
        rx = stop;
        repeat (10) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_word(input logic [15:0] w);
        send_byte(w[15:8], 1'b1);
        send_byte(w[7:0], 1'b1);
    endtask

    task automatic send_frame();
        logic [15:0] x;
        x = '0;
        send_word(16'(fn));
        for (int i = 0; i < fn; i++) begin
            send_word(fw[i]);
            x = x ^ fw[i];
        end
`ifdef LOADER_CHECKSUM_EN
        if (fn > 0) send_word(x);
`endif
    endtask

    task automatic wait_done(input int lim);
        int i;
        i = 0;
        while (!load_done && i < lim) begin
            @(negedge clk);
            i++;
        end
    endtask

    typedef struct packed {
        logic [15:0] hdr;
        logic [15:0] w0;
        logic [15:0] step;
        logic [4:0]  exp_wl;
        logic [3:0]  exp_addr;
        logic        exp_ovf;
    } vec_t;

    vec_t tbl[6];

    initial begin
        tbl[0] = '{hdr: 16'd0,  w0: 16'h0000, step: 16'h0000, exp_wl: 5'd0,  exp_addr: 4'd0,  exp_ovf: 1'b0};
        tbl[1] = '{hdr: 16'd1,  w0: 16'h7777, step: 16'h0000, exp_wl: 5'd1,  exp_addr: 4'd1,  exp_ovf: 1'b0};
        tbl[2] = '{hdr: 16'd5,  w0: 16'h1111, step: 16'h2222, exp_wl: 5'd5,  exp_addr: 4'd5,  exp_ovf: 1'b0};
        tbl[3] = '{hdr: 16'd16, w0: 16'h8000, step: 16'h0001, exp_wl: 5'd16, exp_addr: 4'd15, exp_ovf: 1'b0};
        tbl[4] = '{hdr: 16'd17, w0: 16'hC000, step: 16'h0010, exp_wl: 5'd16, exp_addr: 4'd15, exp_ovf: 1'b1};
        tbl[5] = '{hdr: 16'd20, w0: 16'hA000, step: 16'h0001, exp_wl: 5'd16, exp_addr: 4'd15, exp_ovf: 1'b1};

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_holdN", cpu_holdN, 0);
        chk("rst_we", rom_if.rom_we, 0);
        chk("rst_waddr", rom_if.rom_waddr, 0);
        chk("rst_wdata", rom_if.rom_wdata, 0);
        chk("rst_loading", loading, 0);
        chk("rst_done", load_done, 0);
        chk("rst_wl", words_loaded, 0);
        chk("rst_ferr", frame_error, 0);
        chk("rst_terr", timeout_error, 0);
        chk("rst_ovf", overflow, 0);
`ifdef LOADER_CHECKSUM_EN
        chk("rst_cerr", checksum_error, 0);
`endif

        // Table-driven complete frames
        for (int v = 0; v < 6; v++) begin
            int k;
            do_reset();
            fn = int'(tbl[v].hdr);
            for (int i = 0; i < fn; i++) fw[i] = tbl[v].w0 + 16'(i) * tbl[v].step;
            send_frame();
            wait_done(100);
            k = (fn > 16) ? 16 : fn;
            chk($sformatf("v%0d_nwr", v), wa_q.size(), k);
            for (int i = 0; i < k && i < wa_q.size(); i++) begin
                chk($sformatf("v%0d_addr%0d", v, i), wa_q[i], i);
                chk($sformatf("v%0d_data%0d", v, i), wd_q[i], fw[i]);
            end
            chk($sformatf("v%0d_wl", v), words_loaded, tbl[v].exp_wl);
            chk($sformatf("v%0d_waddr", v), rom_if.rom_waddr, tbl[v].exp_addr);
            chk($sformatf("v%0d_ovf", v), overflow, tbl[v].exp_ovf);
            chk($sformatf("v%0d_holdN", v), cpu_holdN, 1);
            chk($sformatf("v%0d_done", v), load_done, 1);
            chk($sformatf("v%0d_loading", v), loading, 0);
        end

        // N=3 with specific words, loading visible mid-frame
        do_reset();
        send_word(16'd3);
        chk("n3_loading_mid", loading, 1);
        chk("n3_holdN_mid", cpu_holdN, 0);
        fn = 3;
        fw[0] = 16'h1234; fw[1] = 16'hABCD; fw[2] = 16'h0001;
        for (int i = 0; i < 3; i++) send_word(fw[i]);
`ifdef LOADER_CHECKSUM_EN
        send_word(16'h1234 ^ 16'hABCD ^ 16'h0001);
`endif
        wait_done(100);
        chk("n3_nwr", wa_q.size(), 3);
        for (int i = 0; i < 3 && i < wa_q.size(); i++) begin
            chk($sformatf("n3_addr%0d", i), wa_q[i], i);
            chk($sformatf("n3_data%0d", i), wd_q[i], fw[i]);
        end
        chk("n3_wl", words_loaded, 3);
        chk("n3_holdN", cpu_holdN, 1);
        chk("n3_done", load_done, 1);

        // Bad stop bit on second data byte, then a clean N=1 frame
        do_reset();
        send_word(16'd2);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        chk("fe_flag", frame_error, 1);
        chk("fe_holdN", cpu_holdN, 0);
        chk("fe_loading", loading, 0);
        chk("fe_nwr", wa_q.size(), 0);
        fn = 1;
        fw[0] = 16'h7777;
        send_frame();
        wait_done(100);
        chk("fe2_nwr", wa_q.size(), 1);
        if (wa_q.size() > 0) begin
            chk("fe2_addr", wa_q[0], 0);
            chk("fe2_data", wd_q[0], 16'h7777);
        end
        chk("fe2_holdN", cpu_holdN, 1);
        chk("fe2_sticky", frame_error, 1);

        // Idle gap inside a frame, then reset while a new frame is running
        do_reset();
        send_word(16'd2);
        send_word(16'hBEEF);
        chk("to_nwr", wa_q.size(), 1);
        repeat (600) @(negedge clk);
        chk("to_flag", timeout_error, 1);
        chk("to_holdN", cpu_holdN, 0);
        chk("to_loading", loading, 0);
        chk("to_waddr", rom_if.rom_waddr, 0);
        send_byte(8'h00, 1'b1);
        chk("to_restart", loading, 1);
        chk("to_wdata_kept", rom_if.rom_wdata, 16'hBEEF);
        rst_n = 1'b0;
        #1;
        chk("mr_holdN", cpu_holdN, 0);
        chk("mr_loading", loading, 0);
        chk("mr_terr", timeout_error, 0);
        chk("mr_wdata", rom_if.rom_wdata, 0);
        chk("mr_waddr", rom_if.rom_waddr, 0);
        chk("mr_we", rom_if.rom_we, 0);
        chk("mr_wl", words_loaded, 0);

`ifdef LOADER_CHECKSUM_EN
        do_reset();
        send_word(16'd2);
        send_word(16'h00FF);
        send_word(16'h0F0F);
        send_word(16'h0FF0);
        wait_done(100);
        chk("cs_ok_holdN", cpu_holdN, 1);
        chk("cs_ok_cerr", checksum_error, 0);
        do_reset();
        send_word(16'd2);
        send_word(16'h00FF);
        send_word(16'h0F0F);
        send_word(16'h0000);
        repeat (5) @(negedge clk);
        chk("cs_bad_cerr", checksum_error, 1);
        chk("cs_bad_holdN", cpu_holdN, 0);
        chk("cs_bad_loading", loading, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
